// File: rtl/hold_skew_pkg.sv
// Shared types and helpers for the skewed-clock pipeline: FSM states,
// Galois LFSR feedback masks and the per-stage transfer function.
package hold_skew_pkg;

   localparam int ERR_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // Right-shifting Galois feedback masks; widths outside the table fall back
   // to a plain two-tap feedback that is not maximal length.
   function automatic logic [63:0] lfsr_taps(input int w);
      case (w)
         2:       return 64'h3;
         3:       return 64'h6;
         4:       return 64'hC;
         5:       return 64'h14;
         6:       return 64'h30;
         7:       return 64'h60;
         8:       return 64'hB8;
         9:       return 64'h110;
         10:      return 64'h240;
         11:      return 64'h500;
         12:      return 64'hE08;
         13:      return 64'h1C80;
         14:      return 64'h3802;
         15:      return 64'h6000;
         16:      return 64'hB400;
         17:      return 64'h12000;
         18:      return 64'h20400;
         19:      return 64'h72000;
         20:      return 64'h90000;
         21:      return 64'h140000;
         22:      return 64'h300000;
         23:      return 64'h420000;
         24:      return 64'hE10000;
         32:      return 64'h80200003;
         64:      return 64'hD800000000000000;
         default: return (64'd1 << (w - 1)) | 64'd1;
      endcase
   endfunction

   // Stage transfer: identity, or q ^ rotate_right(q, 1) within w bits.
   function automatic logic [63:0] mix(input logic [63:0] q, input int w, input int mode);
      logic [63:0] r;
      r = q >> 1;
      r[w-1] = q[0];
      return (mode == 1) ? (q ^ r) : q;
   endfunction

endpackage

// File: rtl/hold_skew_clk_tap.sv
// Chain of TAPS clock buffer cells between two adjacent stage clocks;
// TAPS = 0 passes the clock straight through.
module hold_skew_clk_tap #(
   parameter int TAPS = 2
) (
   input  logic clk_in,
   output logic clk_out
);
   genvar gi;

   if (TAPS == 0) begin : g_bypass
      assign clk_out = clk_in;
   end else begin : g_chain
      for (gi = 0; gi < TAPS; gi++) begin : g_buf
         logic a;
         logic z;
         if (gi == 0) begin : g_first
            assign a = clk_in;
         end else begin : g_next
            assign a = g_buf[gi-1].z;
         end
         (* dont_touch = "true", keep = "true" *)
         snl_bufx1 u_cell (
            .a (a),
            .z (z)
         );
      end
      assign clk_out = g_buf[TAPS-1].z;
   end
endmodule

// File: rtl/snl_bufx1.sv
// Standard-cell clock buffer as seen by simulation and lint; the library
// view replaces this during implementation.
module snl_bufx1 (
   input  logic a,
   output logic z
);
   assign z = a;
endmodule

// File: rtl/hold_skew_pipe.sv
// LFSR-fed pipeline whose stages run on progressively buffered clocks,
// checked every cycle against an identical pipeline on the root clock.
module hold_skew_pipe
   import hold_skew_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int STAGES    = 4,
   parameter int SKEW_TAPS = 2,
   parameter int MODE      = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WIDTH-1:0]     seed,
   output logic [WIDTH-1:0]     out,
   output logic                 checking,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam logic [63:0]      TAPS64 = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS   = TAPS64[WIDTH-1:0];
   localparam int               CNT_W  = $clog2(STAGES + 1) + 1;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     fill_cnt_reg, fill_cnt_next;
   logic [WIDTH-1:0]     lfsr_reg, lfsr_next, lfsr_step, seed_fix;
   logic [WIDTH-1:0]     gold_out;
   logic                 mismatch;
   logic                 err_reg;
   logic [ERR_CNT_W-1:0] err_cnt_reg;

   genvar gi;

   assign lfsr_step = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);
   assign seed_fix  = (seed == '0) ? WIDTH'(1) : seed;

   always_comb begin
      state_next    = state_reg;
      fill_cnt_next = fill_cnt_reg;
      lfsr_next     = lfsr_reg;
      if (!en) begin
         state_next    = IDLE;
         fill_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next    = FILL;
               fill_cnt_next = '0;
               lfsr_next     = seed_fix;
            end
            FILL: begin
               lfsr_next = lfsr_step;
               // STAGES+1 fill cycles flush pre-load data out of both pipelines
               if (fill_cnt_reg == CNT_W'(STAGES)) begin
                  state_next = CHECK;
               end else begin
                  fill_cnt_next = fill_cnt_reg + 1'b1;
               end
            end
            CHECK: begin
               lfsr_next = lfsr_step;
            end
            default: begin
               state_next    = IDLE;
               fill_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         fill_cnt_reg <= '0;
         lfsr_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         fill_cnt_reg <= fill_cnt_next;
         lfsr_reg     <= lfsr_next;
      end
   end

   // Stage k runs on clk delayed by k*SKEW_TAPS buffer cells.
   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             sclk;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;
      if (gi == 0) begin : g_root
         assign sclk = clk;
         assign d    = lfsr_reg;
      end else begin : g_tap
         hold_skew_clk_tap #(
            .TAPS (SKEW_TAPS)
         ) u_tap (
            .clk_in  (g_stage[gi-1].sclk),
            .clk_out (sclk)
         );
         assign d = WIDTH'(mix(64'(g_stage[gi-1].q), WIDTH, MODE));
      end
      always_ff @(posedge sclk or posedge rst) begin
         if (rst) begin
            q <= '0;
         end else begin
            q <= d;
         end
      end
   end

   for (gi = 0; gi < STAGES; gi++) begin : g_gold
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;
      if (gi == 0) begin : g_src
         assign d = lfsr_reg;
      end else begin : g_mix
         assign d = WIDTH'(mix(64'(g_gold[gi-1].q), WIDTH, MODE));
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q <= '0;
         end else begin
            q <= d;
         end
      end
   end

   assign out      = g_stage[STAGES-1].q;
   assign gold_out = g_gold[STAGES-1].q;
   assign mismatch = (state_reg == CHECK) && (out != gold_out);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg     <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         err_reg <= mismatch;
         if (mismatch && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
         end
      end
   end

   assign checking  = (state_reg == CHECK);
   assign err       = err_reg;
   assign err_count = err_cnt_reg;

endmodule

// File: tb/tb_hold_skew_pipe.sv
// Scoreboard bench: two instances (pass-through and rotate-XOR), directed
// phases, fault injection on the last skewed stage input of the first one.
module tb_hold_skew_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [7:0]  seed0 = 8'h00;
   logic [7:0]  seed1 = 8'h00;
   logic [7:0]  out0, out1;
   logic        chk0, chk1, err0, err1;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   hold_skew_pipe #(.WIDTH(8), .STAGES(4), .SKEW_TAPS(2), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .seed(seed0),
      .out(out0), .checking(chk0), .err(err0), .err_count(cnt0)
   );

   hold_skew_pipe #(.WIDTH(8), .STAGES(4), .SKEW_TAPS(1), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .seed(seed1),
      .out(out1), .checking(chk1), .err(err1), .err_count(cnt1)
   );

   typedef struct packed {
      logic [31:0]      cyc;
      logic             show;
      logic [1:0][7:0]  out;
      logic [1:0]       chk;
      logic [1:0]       err;
      logic [1:0][15:0] cnt;
      logic             hout_en;
      logic [7:0]       hout;
      logic             hcnt_en;
      logic [15:0]      hcnt;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   // reference model state, index = instance (= its MODE)
   logic [7:0]  m_lfsr [2];
   logic [7:0]  m_q [2][4];
   logic [7:0]  m_out [2];
   logic        m_err [2];
   logic [15:0] m_cnt [2];
   int          m_run = 0;

   logic [7:0]  force_val = 8'h00;
   logic        forcing = 1'b0;
   logic        h_out_en = 1'b0;
   logic [7:0]  h_out = 8'h00;
   logic        h_cnt_en = 1'b0;
   logic [15:0] h_cnt = 16'h0000;
   logic [7:0]  hand [8];

   function automatic logic [7:0] f_mix(input logic [7:0] q, input int mode);
      return (mode == 1) ? (q ^ {q[0], q[7:1]}) : q;
   endfunction

   function automatic logic [7:0] f_step(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_lfsr[i] = 8'h00;
         m_out[i]  = 8'h00;
         m_err[i]  = 1'b0;
         m_cnt[i]  = 16'h0000;
         for (int k = 0; k < 4; k++) m_q[i][k] = 8'h00;
      end
      m_run = 0;
   endtask

   task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   // frc: 0 none, 1 flip bit 0 of last-stage D for one capture, 2 drive it to zero
   task automatic step(input logic r, input logic e, input logic [7:0] s0, input logic [7:0] s1,
                       input int frc, input logic show);
      exp_t       x;
      logic [7:0] sd [2];
      logic       mis;
      logic [7:0] fval;
      @(posedge clk);
      #1;
      if (forcing) begin
         release dut0.g_stage[3].d;
         forcing = 1'b0;
      end
      rst = r; en = e; seed0 = s0; seed1 = s1;
      sd[0] = s0; sd[1] = s1;
      if (r) model_clear();
      x = '0;
      x.cyc = cyc;
      x.show = show;
      for (int i = 0; i < 2; i++) begin
         x.out[i] = m_out[i];
         x.chk[i] = (m_run >= 6);
         x.err[i] = m_err[i];
         x.cnt[i] = m_cnt[i];
      end
      x.hout_en = h_out_en; x.hout = h_out;
      x.hcnt_en = h_cnt_en; x.hcnt = h_cnt;
      sb.push_back(x);
      h_out_en = 1'b0;
      h_cnt_en = 1'b0;
      fval = (frc == 1) ? (m_q[0][2] ^ 8'h01) : 8'h00;
      if (frc != 0) begin
         force_val = fval;
         force dut0.g_stage[3].d = force_val;
         forcing = 1'b1;
      end
      if (!r) begin
         for (int i = 0; i < 2; i++) begin
            mis = (m_run >= 6) && (m_out[i] != m_q[i][3]);
            m_err[i] = mis;
            if (mis && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
            for (int k = 3; k > 0; k--) m_q[i][k] = f_mix(m_q[i][k-1], i);
            m_q[i][0] = m_lfsr[i];
            m_out[i] = (i == 0 && frc != 0) ? fval : m_q[i][3];
            if (e) m_lfsr[i] = (m_run == 0) ? ((sd[i] == 8'h00) ? 8'h01 : sd[i]) : f_step(m_lfsr[i]);
         end
         m_run = e ? ((m_run < 100) ? m_run + 1 : m_run) : 0;
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk("out0", x.cyc, 16'(out0), 16'(x.out[0]));
         chk("out1", x.cyc, 16'(out1), 16'(x.out[1]));
         chk("checking0", x.cyc, 16'(chk0), 16'(x.chk[0]));
         chk("checking1", x.cyc, 16'(chk1), 16'(x.chk[1]));
         chk("err0", x.cyc, 16'(err0), 16'(x.err[0]));
         chk("err1", x.cyc, 16'(err1), 16'(x.err[1]));
         chk("err_count0", x.cyc, cnt0, x.cnt[0]);
         chk("err_count1", x.cyc, cnt1, x.cnt[1]);
         if (x.hout_en) chk("hand_out0", x.cyc, 16'(out0), 16'(x.hout));
         if (x.hcnt_en) chk("hand_err_count0", x.cyc, cnt0, x.hcnt);
         if (x.show)
            $display("cyc %0d: out0=%h chk0=%b err0=%b cnt0=%h | out1=%h chk1=%b err1=%b cnt1=%h",
                     x.cyc, out0, chk0, err0, cnt0, out1, chk1, err1, cnt1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      hand[0] = 8'h01; hand[1] = 8'hB8; hand[2] = 8'h5C; hand[3] = 8'h2E;
      hand[4] = 8'h17; hand[5] = 8'hB3; hand[6] = 8'hE1; hand[7] = 8'hC8;
      model_clear();

      // reset state, then idle with en low
      repeat (3) step(1'b1, 1'b0, 8'h01, 8'hA5, 0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 8'h01, 8'hA5, 0, 1'b1);

      // main run: dut0 seed 01 pass-through, dut1 seed A5 rotate-XOR
      for (int i = 0; i < 1000; i++) begin
         if (i >= 5 && i < 13) begin
            h_out_en = 1'b1;
            h_out = hand[i-5];
         end
         step(1'b0, 1'b1, 8'h01, 8'hA5, 0, i < 16);
      end

      // five single-capture faults on dut0
      for (int n = 0; n < 5; n++) begin
         step(1'b0, 1'b1, 8'h01, 8'hA5, 1, 1'b1);
         for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h01, 8'hA5, 0, i < 3);
      end
      h_cnt_en = 1'b1; h_cnt = 16'd5;
      step(1'b0, 1'b1, 8'h01, 8'hA5, 0, 1'b1);

      // asynchronous reset while checking with err_count = 5
      h_cnt_en = 1'b1; h_cnt = 16'd0;
      h_out_en = 1'b1; h_out = 8'h00;
      step(1'b1, 1'b1, 8'h00, 8'h00, 0, 1'b1);

      // restart from seed 0 (loads 1), drop en for 3 cycles, refill
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            h_out_en = 1'b1;
            h_out = 8'h01;
         end
         step(1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b1);
      end
      repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b1);

      // persistent mismatch drives err_count into saturation
      for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 8'h00, 8'h00, 2, (i < 3) || (i > 69996));
      for (int i = 0; i < 5; i++) begin
         h_cnt_en = 1'b1; h_cnt = 16'hFFFF;
         step(1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b1);
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hold_skew_pipe.md
HOLD_SKEW_PIPE -- requirements
Module: hold_skew_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning datapath width in bits (legal range 2..64).
REQ-002 SHALL have parameter STAGES, default 4, meaning register stages in the skewed pipeline (legal range 2..16).
REQ-003 SHALL have parameter SKEW_TAPS, default 2, meaning snl_bufx1 cells inserted between consecutive stage clocks; 0 means all stages use clk directly.
REQ-004 SHALL have parameter MODE, default 0, meaning the stage transfer function: 0 is pass-through, 1 is rotate-XOR mix.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single root clock.
REQ-006 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit, meaning run enable for the source and the checker.
REQ-008 SHALL have port seed, input, WIDTH bits, meaning LFSR load value, sampled on the first en cycle after reset.
REQ-009 SHALL have port out, output, WIDTH bits, meaning the last pipeline stage Q.
REQ-010 SHALL have port checking, output, 1 bit, meaning the FSM is in CHECK.
REQ-011 SHALL have port err, output, 1 bit, meaning a registered single-cycle mismatch pulse.
REQ-012 SHALL have port err_count, output, 16 bits, meaning a saturating mismatch counter.

Function
REQ-013 Source SHALL be a Galois LFSR of WIDTH bits using a maximal-length tap table from the package; a zero seed SHALL load 1.
REQ-014 The LFSR SHALL advance once per root-clk cycle while en=1 and hold while en=0.
REQ-015 Stage 0 SHALL capture the LFSR value; stage k (k>=1) SHALL capture f(q[k-1]); f is identity for MODE=0, and q ^ rotate_right(q,1) for MODE=1.
REQ-016 Stage k SHALL be clocked by clk delayed through k*SKEW_TAPS instantiated snl_bufx1 cells; the cells SHALL be kept from optimisation and SHALL never be behavioural delays.
REQ-017 Pipeline stages SHALL advance every cycle regardless of en.
REQ-018 A golden model SHALL apply the same f over STAGES registers, all clocked by root clk.
REQ-019 FSM states SHALL be IDLE, FILL, and CHECK.
REQ-020 IDLE SHALL go to FILL on en=1, loading the LFSR.
REQ-021 FILL SHALL count STAGES+1 cycles, then go to CHECK.
REQ-022 Any state SHALL go to IDLE when en=0, and the fill counter SHALL clear.
REQ-023 In CHECK, each cycle with out != golden SHALL assert err on the next cycle and increment err_count.
REQ-024 err_count SHALL saturate at 16'hFFFF, and err SHALL still pulse when saturated.
REQ-025 A mismatch on the same cycle as a CHECK to IDLE transition SHALL still be counted.
REQ-026 Latency from LFSR value to out SHALL be STAGES cycles in zero-delay simulation, and out SHALL equal golden every cycle.

Reset
REQ-027 rst=1 SHALL asynchronously clear all stages, golden registers, LFSR, out, err, err_count, and checking, and SHALL force IDLE.
REQ-028 Reset deassertion mid-run SHALL require en=1 plus a full FILL before checking resumes.

Structure
REQ-029 A package hold_skew_pkg SHALL hold the FSM state enum, the LFSR tap table indexed by WIDTH, the mix function f, and ERR_CNT_W=16.
REQ-030 One sub-module hold_skew_clk_tap SHALL implement a SKEW_TAPS-long snl_bufx1 chain, instantiated STAGES-1 times in series.
REQ-031 No logic other than snl_bufx1 cells SHALL sit on clock nets.

Verification
REQ-032 WIDTH=8, STAGES=4, MODE=0, seed=8'h01, en=1 -> checking=1 from cycle 6, err_count stays 0 for 1000 cycles, out equals LFSR delayed by 4 cycles.
REQ-033 MODE=1, seed=8'hA5 -> out matches golden every cycle, err never asserts.
REQ-034 Force one stage Q bit for one cycle during CHECK -> err pulses once, err_count=1.
REQ-035 Force a persistent mismatch for 70000 cycles -> err_count=16'hFFFF and holds.
REQ-036 Assert rst in CHECK with err_count=5 -> all outputs 0 immediately, IDLE, FILL restarts on en.
REQ-037 seed=0 -> LFSR loads 1, out nonzero after 4 cycles, en=0 for 3 cycles forces IDLE then refill.
